// File: rtl/jt12_slot_wr.sv
// Slot sequencer and write injector for a per-slot recirculating delay line.
// Clears the ring after reset, then recirculates din and overwrites one requested slot as it passes.
module jt12_slot_wr #(
    parameter int width  = 8,
    parameter int stages = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             wr_req,
    input  logic [4:0]       wr_slot,
    input  logic [width-1:0] wr_data,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic [4:0]       slot,
    output logic             zero,
    output logic             busy,
    output logic             wr_ack,
    output logic             wr_err
);

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_PEND  = 2'd2;

    localparam logic [4:0] LAST_SLOT = 5'(stages - 1);
    localparam logic [5:0] NUM_SLOTS = 6'(stages);

    logic [1:0]       state;
    logic [4:0]       clr_cnt;
    logic [4:0]       pend_slot;
    logic [width-1:0] pend_data;
    logic             commit;

    assign commit = (state == ST_PEND) && (slot == pend_slot);
    assign zero   = (slot == 5'd0);
    assign busy   = (state != ST_IDLE);

    // The ring input is forced to zero while clearing and replaced by the pending word on its slot.
    always_comb begin
        dout = din;
        if (state == ST_CLEAR)
            dout = '0;
        else if (commit)
            dout = pend_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot      <= 5'd0;
            state     <= ST_CLEAR;
            clr_cnt   <= 5'd0;
            pend_slot <= 5'd0;
            pend_data <= '0;
            wr_ack    <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            // Status pulses last exactly one clk cycle, independent of clk_en.
            wr_ack <= 1'b0;
            wr_err <= 1'b0;
            if (clk_en) begin
                slot <= (slot == LAST_SLOT) ? 5'd0 : slot + 5'd1;
                case (state)
                    ST_CLEAR: begin
                        if (clr_cnt == LAST_SLOT) begin
                            clr_cnt <= 5'd0;
                            state   <= ST_IDLE;
                        end else begin
                            clr_cnt <= clr_cnt + 5'd1;
                        end
                    end
                    ST_IDLE: begin
                        if (wr_req) begin
                            if ({1'b0, wr_slot} < NUM_SLOTS) begin
                                pend_slot <= wr_slot;
                                pend_data <= wr_data;
                                state     <= ST_PEND;
                            end else begin
                                wr_err <= 1'b1;
                            end
                        end
                    end
                    ST_PEND: begin
                        if (commit) begin
                            wr_ack <= 1'b1;
                            state  <= ST_IDLE;
                        end
                    end
                    default: state <= ST_CLEAR;
                endcase
            end
        end
    end

endmodule
